// File: rtl/pc_select_if.sv
// Fetch-PC bus between the hazard/fetch/correction logic (master) and pc_select (slave).
interface pc_select_if #(
  parameter int unsigned RAS_DEPTH = 8
);
  localparam int unsigned CW = $clog2(RAS_DEPTH) + 1;

  logic          f_stall;
  logic          f_ok;
  logic [3:0]    f_icode;
  logic [63:0]   f_valC;
  logic [63:0]   f_valP;
  logic          m_mispredict;
  logic [63:0]   m_valA;
  logic          w_ret_valid;
  logic [63:0]   w_valM;
  logic [63:0]   w_predpc;
  logic [63:0]   f_pc;
  logic [63:0]   f_predpc;
  logic          f_ret_wait;
  logic          redirect;
  logic [CW-1:0] ras_count;

  modport master (
    output f_stall, f_ok, f_icode, f_valC, f_valP,
           m_mispredict, m_valA, w_ret_valid, w_valM, w_predpc,
    input  f_pc, f_predpc, f_ret_wait, redirect, ras_count
  );

  modport slave (
    input  f_stall, f_ok, f_icode, f_valC, f_valP,
           m_mispredict, m_valA, w_ret_valid, w_valM, w_predpc,
    output f_pc, f_predpc, f_ret_wait, redirect, ras_count
  );
endinterface

// File: rtl/pc_select.sv
// Y86 fetch PC register with next-PC prediction and M/W corrections.
// Optional return-address stack enabled by defining RAS_EN.
module pc_select #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int unsigned RAS_DEPTH = 8
) (
  input logic         clk,
  input logic         rst,
  pc_select_if.slave  bus
);
  localparam int unsigned CW = $clog2(RAS_DEPTH) + 1;
  localparam int unsigned PW = $clog2(RAS_DEPTH);

  localparam logic [3:0] I_HALT = 4'h0;
  localparam logic [3:0] I_JXX  = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8;
  localparam logic [3:0] I_RET  = 4'h9;

  typedef enum logic {RUN, RET_WAIT} state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        redirect_q, redirect_d;
  logic [63:0] predpc_c;
  logic        ras_push, ras_pop, ras_clr;
  logic        ras_hit;
  logic [63:0] ras_top;
  logic        ret_redirect;

`ifdef RAS_EN
  logic [63:0]   ras_mem [RAS_DEPTH];
  logic [PW-1:0] wptr_q;
  logic [CW-1:0] cnt_q;
  logic [PW-1:0] top_idx;

  assign top_idx      = wptr_q - PW'(1);
  assign ras_top      = ras_mem[top_idx];
  assign ras_hit      = (cnt_q != '0);
  assign ret_redirect = bus.w_ret_valid && (bus.w_valM != bus.w_predpc);
  assign bus.ras_count = cnt_q;

  // Circular stack: pointer wraps, count saturates so the oldest entry is overwritten when full.
  always_ff @(posedge clk) begin
    if (rst || ras_clr) begin
      wptr_q <= '0;
      cnt_q  <= '0;
    end else if (ras_push) begin
      wptr_q <= wptr_q + PW'(1);
      if (cnt_q != CW'(RAS_DEPTH)) cnt_q <= cnt_q + CW'(1);
    end else if (ras_pop) begin
      wptr_q <= top_idx;
      cnt_q  <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && ras_push) ras_mem[wptr_q] <= bus.f_valP;
  end
`else
  logic unused_ras;

  assign ras_top      = '0;
  assign ras_hit      = 1'b0;
  assign ret_redirect = bus.w_ret_valid;
  assign bus.ras_count = '0;
  assign unused_ras   = ras_push ^ ras_pop ^ ras_clr ^ (^bus.w_predpc);
`endif

  // Next-PC prediction for the instruction currently at f_pc.
  always_comb begin
    predpc_c = pc_q;
    if (state_q == RUN && bus.f_ok) begin
      case (bus.f_icode)
        I_HALT:         predpc_c = pc_q;
        I_JXX, I_CALL:  predpc_c = bus.f_valC;
        I_RET:          predpc_c = ras_hit ? ras_top : bus.f_valP;
        default:        predpc_c = bus.f_valP;
      endcase
    end
  end

  // W ret correction beats M mispredict: W holds the older instruction.
  always_comb begin
    pc_d       = pc_q;
    state_d    = state_q;
    redirect_d = 1'b0;
    ras_push   = 1'b0;
    ras_pop    = 1'b0;
    ras_clr    = 1'b0;
    if (ret_redirect) begin
      pc_d       = bus.w_valM;
      state_d    = RUN;
      ras_clr    = 1'b1;
      redirect_d = 1'b1;
    end else if (bus.m_mispredict) begin
      pc_d       = bus.m_valA;
      ras_clr    = 1'b1;
      redirect_d = 1'b1;
    end else if (bus.f_stall || state_q == RET_WAIT) begin
      pc_d = pc_q;
    end else if (bus.f_ok) begin
      pc_d = predpc_c;
      if (bus.f_icode == I_CALL) begin
        ras_push = 1'b1;
      end else if (bus.f_icode == I_RET) begin
        if (ras_hit) ras_pop = 1'b1;
        else         state_d = RET_WAIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      state_q    <= RUN;
      redirect_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      state_q    <= state_d;
      redirect_q <= redirect_d;
    end
  end

  assign bus.f_pc       = pc_q;
  assign bus.f_predpc   = predpc_c;
  assign bus.f_ret_wait = (state_q == RET_WAIT);
  assign bus.redirect   = redirect_q;
endmodule

// File: tb/tb_pc_select.sv
// Directed scoreboard bench for pc_select; covers both RAS_EN and default builds.
module tb_pc_select;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  typedef struct {
    string         tag;
    logic [63:0]   pc;
    logic          red;
    logic          rw;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  pc_select_if #(.RAS_DEPTH(DEPTH)) bus ();

  pc_select #(.RESET_PC(64'h0), .RAS_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic idle();
    bus.f_stall      = 1'b0;
    bus.f_ok         = 1'b0;
    bus.f_icode      = 4'h1;
    bus.f_valC       = '0;
    bus.f_valP       = '0;
    bus.m_mispredict = 1'b0;
    bus.m_valA       = '0;
    bus.w_ret_valid  = 1'b0;
    bus.w_valM       = '0;
    bus.w_predpc     = '0;
  endtask

  task automatic fetch(input logic [3:0] icode, input logic [63:0] valc, input logic [63:0] valp);
    bus.f_ok    = 1'b1;
    bus.f_icode = icode;
    bus.f_valC  = valc;
    bus.f_valP  = valp;
  endtask

  task automatic pred(input string tag, input logic [63:0] exp);
    #1;
    n_cmp++;
    assert (bus.f_predpc === exp) else begin
      n_err++;
      $error("FAIL %s: f_predpc got %h want %h", tag, bus.f_predpc, exp);
    end
  endtask

  // Push the expected post-edge state, clock once, then pop and compare.
  task automatic step(input string tag, input logic [63:0] pc, input logic red,
                      input logic rw, input logic [CW-1:0] cnt);
    exp_t e;
    e.tag = tag; e.pc = pc; e.red = red; e.rw = rw; e.cnt = cnt;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      n_cmp++;
      assert (bus.f_pc === e.pc) else begin
        n_err++;
        $error("FAIL %s.f_pc: got %h want %h", e.tag, bus.f_pc, e.pc);
      end
      n_cmp++;
      assert (bus.redirect === e.red) else begin
        n_err++;
        $error("FAIL %s.redirect: got %b want %b", e.tag, bus.redirect, e.red);
      end
      n_cmp++;
      assert (bus.f_ret_wait === e.rw) else begin
        n_err++;
        $error("FAIL %s.f_ret_wait: got %b want %b", e.tag, bus.f_ret_wait, e.rw);
      end
      n_cmp++;
      assert (bus.ras_count === e.cnt) else begin
        n_err++;
        $error("FAIL %s.ras_count: got %0d want %0d", e.tag, bus.ras_count, e.cnt);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    step("reset", 64'h0, 1'b0, 1'b0, '0);
    rst = 1'b0;

    fetch(4'h6, 64'h0, 64'h2);
    pred("pred_op", 64'h2);
    step("op", 64'h2, 1'b0, 1'b0, '0);

    fetch(4'h7, 64'h40, 64'h1b);
    pred("pred_jxx", 64'h40);
    step("jxx", 64'h40, 1'b0, 1'b0, '0);
    idle();
    step("hold1", 64'h40, 1'b0, 1'b0, '0);
    step("hold2", 64'h40, 1'b0, 1'b0, '0);
    bus.m_mispredict = 1'b1;
    bus.m_valA       = 64'hA;
    step("mispredict", 64'hA, 1'b1, 1'b0, '0);
    idle();
    step("redirect_end", 64'hA, 1'b0, 1'b0, '0);

    fetch(4'h0, 64'h5, 64'hB);
    pred("pred_halt", 64'hA);
    step("halt", 64'hA, 1'b0, 1'b0, '0);
    fetch(4'h6, 64'h5, 64'h99);
    bus.f_ok = 1'b0;
    pred("pred_not_ok", 64'hA);
    step("not_ok", 64'hA, 1'b0, 1'b0, '0);

`ifdef RAS_EN
    fetch(4'h8, 64'h100, 64'h9);
    pred("pred_call", 64'h100);
    step("call", 64'h100, 1'b0, 1'b0, CW'(1));
    fetch(4'h9, 64'h0, 64'h102);
    pred("pred_ret_ras", 64'h9);
    step("ret_ras", 64'h9, 1'b0, 1'b0, CW'(0));
    idle();
    bus.w_ret_valid = 1'b1;
    bus.w_valM      = 64'h9;
    bus.w_predpc    = 64'h9;
    step("w_ret_match", 64'h9, 1'b0, 1'b0, CW'(0));

    fetch(4'h8, 64'h100, 64'h9);
    bus.w_ret_valid = 1'b0;
    step("call2", 64'h100, 1'b0, 1'b0, CW'(1));
    fetch(4'h9, 64'h0, 64'h102);
    step("ret2", 64'h9, 1'b0, 1'b0, CW'(0));
    idle();
    bus.w_ret_valid = 1'b1;
    bus.w_valM      = 64'h20;
    bus.w_predpc    = 64'h9;
    step("w_ret_miss", 64'h20, 1'b1, 1'b0, CW'(0));
    idle();
    step("w_ret_miss_end", 64'h20, 1'b0, 1'b0, CW'(0));

    for (int i = 1; i <= 9; i++) begin
      fetch(4'h8, 64'h200, 64'(i));
      step("call_fill", 64'h200, 1'b0, 1'b0, CW'((i > 8) ? 8 : i));
    end
    for (int k = 0; k < 8; k++) begin
      fetch(4'h9, 64'h0, 64'h300);
      pred("pred_ret_drain", 64'(9 - k));
      step("ret_drain", 64'(9 - k), 1'b0, 1'b0, CW'(7 - k));
    end
    fetch(4'h9, 64'h0, 64'h301);
    pred("pred_ret_empty", 64'h301);
    step("ret_empty", 64'h301, 1'b0, 1'b1, CW'(0));
    fetch(4'h6, 64'h0, 64'h302);
    pred("pred_wait", 64'h301);
    step("wait_hold", 64'h301, 1'b0, 1'b1, CW'(0));
    idle();
    bus.w_ret_valid  = 1'b1;
    bus.w_valM       = 64'h50;
    bus.w_predpc     = 64'h301;
    bus.m_mispredict = 1'b1;
    bus.m_valA       = 64'h60;
    step("w_beats_m", 64'h50, 1'b1, 1'b0, CW'(0));
`else
    fetch(4'h9, 64'h0, 64'h31);
    pred("pred_ret_noras", 64'h31);
    step("ret_wait", 64'h31, 1'b0, 1'b1, '0);
    for (int i = 0; i < 4; i++) begin
      fetch(4'h7, 64'h444, 64'h33);
      pred("pred_in_wait", 64'h31);
      step("wait_hold", 64'h31, 1'b0, 1'b1, '0);
    end
    idle();
    bus.w_ret_valid = 1'b1;
    bus.w_valM      = 64'h77;
    bus.w_predpc    = 64'h31;
    step("w_ret_resume", 64'h77, 1'b1, 1'b0, '0);
    idle();
    fetch(4'h8, 64'h100, 64'h9);
    step("call_noras", 64'h100, 1'b0, 1'b0, '0);
    fetch(4'h9, 64'h0, 64'h102);
    step("ret_after_call", 64'h102, 1'b0, 1'b1, '0);
    idle();
    bus.w_ret_valid  = 1'b1;
    bus.w_valM       = 64'h50;
    bus.w_predpc     = 64'h102;
    bus.m_mispredict = 1'b1;
    bus.m_valA       = 64'h60;
    step("w_beats_m", 64'h50, 1'b1, 1'b0, '0);
`endif
    idle();
    step("after_dual", 64'h50, 1'b0, 1'b0, '0);

    fetch(4'h9, 64'h0, 64'h70);
    step("ret_wait2", 64'h70, 1'b0, 1'b1, '0);
    idle();
    bus.m_mispredict = 1'b1;
    bus.m_valA       = 64'h88;
    step("m_in_wait", 64'h88, 1'b1, 1'b1, '0);
    idle();
    bus.w_ret_valid = 1'b1;
    bus.w_valM      = 64'h90;
    bus.w_predpc    = 64'h70;
    rst = 1'b1;
    step("rst_in_wait", 64'h0, 1'b0, 1'b0, '0);
    rst = 1'b0;
    idle();

    fetch(4'h8, 64'h500, 64'h11);
    bus.f_stall = 1'b1;
    step("stall_call", 64'h0, 1'b0, 1'b0, '0);
    bus.f_stall = 1'b0;
`ifdef RAS_EN
    step("unstall_call", 64'h500, 1'b0, 1'b0, CW'(1));
    fetch(4'h9, 64'h0, 64'h12);
    bus.f_stall = 1'b1;
    step("stall_ret", 64'h500, 1'b0, 1'b0, CW'(1));
    idle();
    bus.m_mispredict = 1'b1;
    bus.m_valA       = 64'hC0;
    step("m_clears_ras", 64'hC0, 1'b1, 1'b0, CW'(0));
`else
    step("unstall_call", 64'h500, 1'b0, 1'b0, '0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pc_select.md
Name: pc_select

Overview:
- Fetch-side program-counter register for the pipelined Y86 core: holds `f_pc`, predicts the next PC from the instruction currently being fetched, and accepts late corrections from memory and write-back.
- Prediction rules: `jXX` predicted taken; `call` predicted to `valC`; `ret` predicted from an optional return-address stack (RAS).
- Corrections: a mispredicted `jXX` from M, or a resolved `ret` from W, redirects fetch.
- The block supplies the PC; the downstream next-PC resolution logic produces the correct PC that it must agree with.

Parameters:
- RESET_PC, 64'h0, value loaded into `f_pc` on reset.
- RAS_DEPTH, 8, number of RAS entries; must be a power of 2, at least 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- f_stall  in  1  hazard-unit hold; PC, state and RAS frozen.
- f_ok  in  1  fetched instruction valid (no imem error, valid icode).
- f_icode  in  4  icode of the instruction at `f_pc`.
- f_valC  in  64  constant word of the fetched instruction.
- f_valP  in  64  fall-through address of the fetched instruction.
- m_mispredict  in  1  `jXX` in M resolved not-taken.
- m_valA  in  64  correct fall-through PC for the mispredicted `jXX`.
- w_ret_valid  in  1  `ret` in W with valid `W_valM`.
- w_valM  in  64  actual return address.
- w_predpc  in  64  PC predicted for that `ret` at fetch, carried down the pipe.
- f_pc  out  64  current fetch PC (registered).
- f_predpc  out  64  combinational next-PC prediction for the current instruction.
- f_ret_wait  out  1  high in state RET_WAIT; fetch issues bubbles.
- redirect  out  1  registered one-cycle pulse; `f_pc` was loaded from a correction.
- ras_count  out  log2(RAS_DEPTH)+1  valid RAS entries.

Behaviour:
- Clocking and reset: one clock `clk`; reset `rst` is synchronous, active-high.
  - Reset values: `f_pc`=RESET_PC, state=RUN, `ras_count`=0, `redirect`=0, `f_ret_wait`=0.
  - Reset overrides every other input, including mid-RET_WAIT and a simultaneous correction.
- States:
  - RUN: normal prediction.
  - RET_WAIT: unpredicted `ret` in flight; `f_pc` held.
- Prediction in RUN (`f_predpc`):
  - icode 7 (`jXX`) -> `f_valC`.
  - icode 8 (`call`) -> `f_valC`.
  - icode 9 (`ret`) -> RAS top if `ras_count`>0 and RAS enabled; otherwise `f_valP`.
  - icode 0 (`halt`) -> `f_pc`.
  - any other icode -> `f_valP`.
  - `f_ok`=0 -> `f_pc`.
  - In RET_WAIT, `f_predpc` = `f_pc`.
- Next-state priority per edge (first match wins):
  1. `rst`.
  2. Ret redirect: `w_ret_valid` and (RAS disabled, or RAS_EN and `w_valM` != `w_predpc`) -> `f_pc`=`w_valM`; state=RUN; RAS cleared; `redirect`=1 next cycle.
  3. Ret match: `w_ret_valid` and RAS_EN and `w_valM` == `w_predpc` -> no correction; normal path below applies.
  4. `m_mispredict` -> `f_pc`=`m_valA`; RAS cleared; `redirect`=1. If state is RET_WAIT it remains RET_WAIT.
  5. `f_stall` -> everything held; a push/pop decoded this cycle is not performed.
  6. State RET_WAIT -> hold.
  7. RUN with `f_ok`=1:
     - `f_pc` <= `f_predpc`.
     - `call` pushes `f_valP`.
     - `ret` with RAS hit pops.
     - `ret` without a prediction: `f_pc` <= `f_valP`, state -> RET_WAIT.
- Simultaneous W ret and M mispredict: W wins (older instruction); the M redirect is discarded.
- RAS is circular with a write pointer.
  - Push while full overwrites the oldest entry; `ras_count` saturates at RAS_DEPTH; pointer wraps modulo RAS_DEPTH.
  - Pop while empty cannot occur (falls back to RET_WAIT).
  - Push and pop in the same cycle are impossible (one instruction per cycle).
- `redirect` is 0 in every cycle not immediately following a correction.
- Latency: prediction is visible in `f_pc` 1 cycle after fetch; correction is visible 1 cycle after `m_mispredict`/`w_ret_valid`.

Optional Feature:
- Macro: RAS_EN.
- Defined: RAS instantiated; `ret` predicted from the RAS top; W compares `w_valM` against `w_predpc` and redirects only on mismatch.
- Undefined:
  - No RAS storage; `ras_count` tied to 0.
  - Every `ret` enters RET_WAIT.
  - Every `w_ret_valid` redirects to `w_valM` (a redirect from RET_WAIT resumes fetch).

Test Plan:
- Reset then `f_ok`=1, icode 6, `f_valP`=0x2 -> next cycle `f_pc`=0x2; `redirect`=0.
- icode 7, `f_valC`=0x40 -> `f_pc`=0x40; 3 cycles later `m_mispredict`=1, `m_valA`=0xA -> `f_pc`=0xA, `redirect` pulse of exactly 1 cycle, `ras_count`=0.
- RAS_EN: `call` `f_valC`=0x100 `f_valP`=0x9, then `ret` -> `f_pc`=0x9, `ras_count` 1->0.
  - `w_ret_valid` with `w_valM`=`w_predpc`=0x9 -> no redirect.
  - Repeat with `w_valM`=0x20 -> `f_pc`=0x20, `redirect`=1.
- RAS undefined: `ret` `f_valP`=0x31 -> `f_pc`=0x31, `f_ret_wait`=1 held 4 cycles; `w_ret_valid`, `w_valM`=0x77 -> `f_pc`=0x77, `f_ret_wait`=0.
- RAS_EN, RAS_DEPTH=8: 9 calls with `f_valP`=1..9 -> `ras_count`=8; 8 rets predict 9,8,...,2; 9th ret enters RET_WAIT.
- Same edge `w_ret_valid` (`w_valM`=0x50, mismatch) and `m_mispredict` (`m_valA`=0x60) -> `f_pc`=0x50.
  - `rst` in RET_WAIT -> `f_pc`=RESET_PC, state RUN.
  - `f_stall` with `call` -> PC and `ras_count` unchanged.
